// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU on port 0, loader/debug on port 1.
// Define DMEM_ARB_PERF_EN to add saturating grant and port-1 stall counters.
module dmem_arbiter #(
    parameter int BITNESS = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               p0_valid_i,
    output logic               p0_ready_o,
    input  logic [BITNESS-1:0] p0_addr_i,
    input  logic [BITNESS-1:0] p0_wdata_i,
    input  logic               p0_we_i,
    input  logic [2:0]         p0_ctrl_i,
    output logic               p0_rsp_valid_o,
    input  logic               p1_valid_i,
    output logic               p1_ready_o,
    input  logic [BITNESS-1:0] p1_addr_i,
    input  logic [BITNESS-1:0] p1_wdata_i,
    input  logic               p1_we_i,
    input  logic [2:0]         p1_ctrl_i,
    output logic               p1_rsp_valid_o,
    output logic [BITNESS-1:0] rsp_data_o,
    output logic               cpu_stall_o,
    output logic [BITNESS-1:0] mem_addr_o,
    output logic [BITNESS-1:0] mem_wdata_o,
    output logic               mem_we_o,
    output logic [2:0]         mem_ctrl_o,
    input  logic [BITNESS-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
   ,output logic [31:0]        p0_grants_o,
    output logic [31:0]        p1_grants_o,
    output logic [31:0]        p1_stall_cycles_o
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               first_q, first_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BITNESS-1:0] addr_q, addr_d;
    logic [BITNESS-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [BITNESS-1:0] rsp_q, rsp_d;
    logic               grant;

    // Tie goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        if (p0_valid_i && p1_valid_i) grant = ~last_q;
        else                          grant = p1_valid_i;
    end

    assign p0_ready_o     = (state_q == IDLE) && p0_valid_i && !grant;
    assign p1_ready_o     = (state_q == IDLE) && p1_valid_i && grant;
    assign p0_rsp_valid_o = (state_q == RESP) && !owner_q;
    assign p1_rsp_valid_o = (state_q == RESP) && owner_q;
    assign cpu_stall_o    = p0_valid_i && !p0_rsp_valid_o;
    assign rsp_data_o     = rsp_q;
    // Memory-side address/data/ctrl come straight from the latches, so they hold between accesses.
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_ctrl_o     = ctrl_q;
    assign mem_we_o       = (state_q == ACCESS) && first_q && we_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ctrl_d  = ctrl_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (p0_valid_i || p1_valid_i) begin
                    addr_d  = grant ? p1_addr_i  : p0_addr_i;
                    wdata_d = grant ? p1_wdata_i : p0_wdata_i;
                    we_d    = grant ? p1_we_i    : p0_we_i;
                    ctrl_d  = grant ? p1_ctrl_i  : p0_ctrl_i;
                    owner_d = grant;
                    last_d  = grant;
                    cnt_d   = 4'(MEM_LAT - 1);
                    first_d = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    rsp_d   = we_q ? '0 : mem_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ctrl_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] p0_grants_q, p1_grants_q, p1_stall_q;
    logic        p1_owns;

    assign p1_owns = (state_q != IDLE) && owner_q;

    // All counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            p0_grants_q <= '0;
            p1_grants_q <= '0;
            p1_stall_q  <= '0;
        end else begin
            if (p0_ready_o && (p0_grants_q != '1)) p0_grants_q <= p0_grants_q + 32'd1;
            if (p1_ready_o && (p1_grants_q != '1)) p1_grants_q <= p1_grants_q + 32'd1;
            if (p0_valid_i && p1_owns && (p1_stall_q != '1)) p1_stall_q <= p1_stall_q + 32'd1;
        end
    end

    assign p0_grants_o       = p0_grants_q;
    assign p1_grants_o       = p1_grants_q;
    assign p1_stall_cycles_o = p1_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected responses/writes, a negedge monitor checks them.
module tb_dmem_arbiter;
    localparam int LAT = 3;
    localparam int W   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         vld[2];
    logic [W-1:0] addr[2];
    logic [W-1:0] wdata[2];
    logic         we[2];
    logic [2:0]   ctl[2];

    logic         p0_ready_o, p1_ready_o, p0_rsp_valid_o, p1_rsp_valid_o;
    logic         cpu_stall_o, mem_we_o;
    logic [W-1:0] rsp_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]   mem_ctrl_o;
    logic [1:0]   rdy;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]  p0_grants_o, p1_grants_o, p1_stall_cycles_o;
`endif

    assign rdy = {p1_ready_o, p0_ready_o};

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    assign mem_rdata_i = mdl(mem_addr_o);

    dmem_arbiter #(.BITNESS(W), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_valid_i(vld[0]), .p0_ready_o(p0_ready_o), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
        .p0_we_i(we[0]), .p0_ctrl_i(ctl[0]), .p0_rsp_valid_o(p0_rsp_valid_o),
        .p1_valid_i(vld[1]), .p1_ready_o(p1_ready_o), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
        .p1_we_i(we[1]), .p1_ctrl_i(ctl[1]), .p1_rsp_valid_o(p1_rsp_valid_o),
        .rsp_data_o(rsp_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_ctrl_o(mem_ctrl_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_PERF_EN
       ,.p0_grants_o(p0_grants_o), .p1_grants_o(p1_grants_o), .p1_stall_cycles_o(p1_stall_cycles_o)
`endif
    );

    typedef struct {int p; logic [31:0] d; int c;} rsp_t;
    typedef struct {logic [31:0] a; logic [31:0] wd; logic [2:0] ct; int c;} wr_t;
    typedef struct {int p; int c;} gnt_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    gnt_t glog[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit p0_due();
        foreach (rsp_q[i]) if (rsp_q[i].p == 0 && rsp_q[i].c == cyc) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every response strobe and every memory write must match the head of its queue.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (rst_n) begin
            if (p0_rsp_valid_o || p1_rsp_valid_o) begin
                chk("rsp_onehot", 32'(p0_rsp_valid_o & p1_rsp_valid_o), 32'd0);
                if (rsp_q.size() == 0) chk("rsp_pending", 32'(rsp_q.size()), 32'd1);
                else begin
                    e = rsp_q.pop_front();
                    chk("rsp_port", 32'(p1_rsp_valid_o), 32'(e.p));
                    chk("rsp_data", rsp_data_o, e.d);
                    chk("rsp_cycle", 32'(cyc), 32'(e.c));
                end
            end
            if (mem_we_o) begin
                if (wr_q.size() == 0) chk("wr_pending", 32'(wr_q.size()), 32'd1);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr_o, w.a);
                    chk("wr_data", mem_wdata_o, w.wd);
                    chk("wr_ctrl", 32'(mem_ctrl_o), 32'(w.ct));
                    chk("wr_cycle", 32'(cyc), 32'(w.c));
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that accepted the request.
    task automatic req(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic w, input logic [2:0] ct);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        addr[p] = a; wdata[p] = wd; we[p] = w; ctl[p] = ct; vld[p] = 1'b1;
        while (n < 200 && !ok) begin
            @(negedge clk);
            if (rdy[p]) ok = 1'b1;
            else begin
                if (p == 0 && !p0_due()) chk("stall_wait", 32'(cpu_stall_o), 32'd1);
                n++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout port=%0d act=no_ready exp=ready", p);
        end else begin
            rsp_q.push_back('{p, w ? 32'd0 : mdl(a), cyc + LAT + 1});
            if (w) wr_q.push_back('{a, wd, ct, cyc + 1});
            glog.push_back('{p, cyc});
        end
        @(posedge clk);
        #1 vld[p] = 1'b0;
    endtask

    task automatic chk_glog(input logic [15:0] pat, input int n);
        chk("grant_count", 32'(glog.size()), 32'(n));
        for (int i = 0; i < n && i < glog.size(); i++) begin
            chk("grant_port", 32'(glog[i].p), 32'(pat[i]));
            if (i > 0) chk("grant_gap", 32'(glog[i].c - glog[i-1].c), 32'(LAT + 2));
        end
        glog.delete();
    endtask

    task automatic drain();
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; addr[i] = '0; wdata[i] = '0; we[i] = 1'b0; ctl[i] = '0;
        end
        #12;
        chk("rst_p0_ready", 32'(p0_ready_o), 32'd0);
        chk("rst_p1_ready", 32'(p1_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both ports valid continuously: strict alternation starting with port 0.
        fork
            begin
                for (int i = 0; i < 5; i++) req(0, 32'(32'h100 + 4*i), 32'd0, 1'b0, 3'b010);
            end
            begin
                for (int j = 0; j < 5; j++) req(1, 32'(32'h200 + 4*j), 32'(32'h1000 + j), j[0], 3'b010);
            end
        join
        chk_glog(16'h02AA, 10);
        drain();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_p0_grants", p0_grants_o, 32'd5);
        chk("perf_p1_grants", p1_grants_o, 32'd5);
        checks++;
        if (p1_stall_cycles_o == 32'd0) begin
            errors++;
            $display("FAIL perf_p1_stall act=%h exp=nonzero", p1_stall_cycles_o);
        end
        force dut.p0_grants_q = 32'hFFFFFFFF;
        @(posedge clk);
        #1 release dut.p0_grants_q;
        req(0, 32'h180, 32'd0, 1'b0, 3'b000);
        glog.delete();
        drain();
        chk("perf_p0_sat", p0_grants_o, 32'hFFFFFFFF);
`endif

        // CPU load at 0x10, valid held until the response cycle.
        addr[0] = 32'h10; wdata[0] = '0; we[0] = 1'b0; ctl[0] = 3'b010; vld[0] = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(p0_ready_o), 32'd1);
        chk("t1_stall_acc", 32'(cpu_stall_o), 32'd1);
        rsp_q.push_back('{0, 32'hDEADBEEF, cyc + LAT + 1});
        repeat (LAT) begin
            @(negedge clk);
            chk("t1_stall_busy", 32'(cpu_stall_o), 32'd1);
            chk("t1_ready_busy", 32'(p0_ready_o), 32'd0);
            chk("t1_no_we", 32'(mem_we_o), 32'd0);
        end
        @(negedge clk);
        chk("t1_stall_rsp", 32'(cpu_stall_o), 32'd0);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        drain();

        // Loader store: one write pulse, zero read data.
        req(1, 32'h20, 32'h000000AB, 1'b1, 3'b010);
        chk_glog(16'h0001, 1);
        drain();

        // Port 1 busy when CPU arrives: CPU must win the next slot despite p1 still valid.
        fork
            begin
                req(1, 32'h30, 32'd0, 1'b0, 3'b001);
                req(1, 32'h34, 32'd0, 1'b0, 3'b001);
            end
            begin
                repeat (2) @(posedge clk);
                #1 req(0, 32'h40, 32'h12345678, 1'b1, 3'b010);
            end
        join
        chk_glog(16'h0005, 3);
        drain();

        // Reset during the write cycle of a store drops the transaction.
        addr[1] = 32'h50; wdata[1] = 32'h55; we[1] = 1'b1; ctl[1] = 3'b000; vld[1] = 1'b1;
        @(negedge clk);
        chk("t5_ready", 32'(p1_ready_o), 32'd1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        chk("t5_we_before", 32'(mem_we_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_we_after", 32'(mem_we_o), 32'd0);
        chk("t5_rsp_after", 32'({p1_rsp_valid_o, p0_rsp_valid_o}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
        fork
            req(0, 32'h60, 32'd0, 1'b0, 3'b010);
            req(1, 32'h64, 32'd0, 1'b0, 3'b010);
        join
        chk_glog(16'h0002, 2);
        drain();

        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path, port 1 is the debug/loader port.
- Sequences each access through a fixed-latency memory cycle and returns a one-cycle response to the requester that owns the access.
- Drives a stall to the CPU while its access is pending.
- Sits between the core/loader and the datamemory block.

Parameters:
- BITNESS, 32, data and address width
- MEM_LAT, 1, memory access cycles per transaction, legal range 1..15

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- p0_valid_i  in  1  CPU request valid
- p0_ready_o  out  1  CPU request accepted this cycle
- p0_addr_i  in  BITNESS  CPU byte address
- p0_wdata_i  in  BITNESS  CPU store data
- p0_we_i  in  1  CPU store (1) or load (0)
- p0_ctrl_i  in  3  CPU funct3 access size/sign, passed to memory
- p0_rsp_valid_o  out  1  CPU response strobe
- p1_valid_i, p1_ready_o, p1_addr_i, p1_wdata_i, p1_we_i, p1_ctrl_i, p1_rsp_valid_o  same as p0, for the loader port
- rsp_data_o  out  BITNESS  read data, qualified by either rsp_valid
- cpu_stall_o  out  1  CPU must hold its PC/instruction
- mem_addr_o  out  BITNESS  to datamemory address
- mem_wdata_o  out  BITNESS  to datamemory write_data
- mem_we_o  out  1  to datamemory write_enable
- mem_ctrl_o  out  3  to datamemory DATAMEMControl
- mem_rdata_i  in  BITNESS  from datamemory read_data

Behaviour:
- FSM has three states: IDLE, ACCESS, RESP.
- Reset (rst_i low, asynchronous):
  - state is IDLE; last-grant register is 1, so port 0 wins the first tie.
  - Access counter is 0; all mem_*_o, rsp_data_o, both rsp_valid and both ready outputs are 0.
  - Reset mid-transaction drops the transaction: no response and no further mem_we_o.
- IDLE arbitration:
  - Only one valid: that port wins.
  - Both valid: the port not named in last-grant wins (round-robin).
- IDLE acceptance:
  - pX_ready_o is combinational and high only for the winner, in IDLE, while its valid is high.
  - On the accepting edge: latch addr, wdata, we and ctrl; record the owner; update last-grant; load the counter with MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_addr_o, mem_wdata_o and mem_ctrl_o come from the latched registers.
  - mem_we_o is high for the first ACCESS cycle only, and only for stores.
  - Counter decrements each cycle. When it is 0: capture mem_rdata_i into rsp_data_o for loads, or 0 for stores; go to RESP.
- RESP:
  - The owner's rsp_valid_o is high for exactly one cycle; there is no backpressure.
  - Then go to IDLE. A new request can be accepted on the next cycle.
- Timing:
  - Request accepted at edge N gives the response at cycle N+MEM_LAT+1.
  - Peak throughput is one transaction per MEM_LAT+2 cycles.
- Request-side rules:
  - Requesters hold valid and payload stable until ready.
  - Deasserting valid before ready is legal and creates no transaction.
- Outside ACCESS, mem_we_o is 0 and mem_addr_o/mem_wdata_o/mem_ctrl_o hold their last values.
- cpu_stall_o = p0_valid_i AND NOT p0_rsp_valid_o. The CPU releases the stall in its response cycle.
- rsp_data_o holds its value until the next capture.
- The arbiter does not check address alignment or range; ctrl is passed through unchanged.

Optional Feature:
- Macro DMEM_ARB_PERF_EN adds three outputs:
  - p0_grants_o and p1_grants_o (32-bit): count accepted transactions per port.
  - p1_stall_cycles_o (32-bit): counts cycles where p0_valid_i is high but port 1 owns the access.
- All counters reset to 0, saturate at all-ones, and never wrap.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. MEM_LAT=1; p0 load addr 0x10 with mem_rdata_i=0xDEADBEEF -> p0_ready_o in cycle 0, mem_we_o never high, p0_rsp_valid_o in cycle 2 with rsp_data_o=0xDEADBEEF, cpu_stall_o high in cycles 0-1 and low in cycle 2.
2. MEM_LAT=3; p1 store addr 0x20 data 0x000000AB ctrl 3'b010 -> mem_we_o high for exactly one cycle with mem_addr_o=0x20, p1_rsp_valid_o 4 cycles after acceptance, rsp_data_o=0.
3. Both ports valid from reset, continuously -> grants alternate p0, p1, p0, p1; each port gets a response every 2*(MEM_LAT+2) cycles.
4. p1 in ACCESS when p0 raises valid -> p0_ready_o stays 0 until IDLE; cpu_stall_o high throughout; p0 granted next even with p1 still valid.
5. Assert rst_i low during ACCESS of a store -> mem_we_o falls immediately, no rsp_valid; after release, the first tie goes to port 0.
6. With DMEM_ARB_PERF_EN, run scenario 3 for 10 grants -> p0_grants_o=5, p1_grants_o=5, p1_stall_cycles_o nonzero; force the count near all-ones -> holds at 0xFFFFFFFF.
